// File: rtl/adc_mem_capture_if.sv
// Simple-dual-port BRAM write bus driven by the ADC capture engine.
// The capture engine drives through the master modport; the BRAM or a bench observes through the slave modport.
interface adc_mem_capture_if #(
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic [31:0]           data;

    modport master (output addr, wr_en, data);
    modport slave  (input  addr, wr_en, data);
endinterface

// File: rtl/adc_mem_capture.sv
// Records a block of dual-channel ADC samples into BRAM as {2'b0,ch1,2'b0,ch0} words,
// with immediate or trigger-edge start and 1-in-(decim+1) decimation.
module adc_mem_capture #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_start,
    input  logic                  cap_abort,
    input  logic [ADDR_WIDTH-1:0] cap_len,
    input  logic [7:0]            cap_decim,
    input  logic                  trig_mode,
    input  logic                  trig,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_ch0,
    input  logic [DATA_WIDTH-1:0] adc_ch1,
    adc_mem_capture_if.master     mem,
    output logic                  cap_busy,
    output logic                  cap_done,
    output logic [ADDR_WIDTH:0]   cap_count
);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] last_ptr;
    logic [7:0]            decim_q;
    logic [7:0]            decim_cnt;
    logic                  trig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            last_ptr  <= '0;
            decim_q   <= '0;
            decim_cnt <= '0;
            trig_q    <= 1'b0;
            mem.addr  <= '0;
            mem.wr_en <= 1'b0;
            mem.data  <= '0;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
            cap_count <= '0;
        end else begin
            mem.wr_en <= 1'b0;
            // Sampled every cycle so a trigger already high at start is not seen as an edge.
            trig_q    <= trig;
            if (cap_abort) begin
                state    <= IDLE;
                cap_busy <= 1'b0;
                cap_done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (cap_start) begin
                            // len-1 wraps so that len=0 ends on the last buffer address.
                            last_ptr  <= cap_len - 1'b1;
                            decim_q   <= cap_decim;
                            decim_cnt <= '0;
                            wr_ptr    <= '0;
                            cap_count <= '0;
                            cap_done  <= 1'b0;
                            cap_busy  <= 1'b1;
                            state     <= trig_mode ? ARM : CAPTURE;
                        end
                    end
                    ARM: begin
                        if (trig && !trig_q) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (adc_valid) begin
                            decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + 1'b1;
                            if (decim_cnt == '0) begin
                                mem.wr_en <= 1'b1;
                                mem.addr  <= wr_ptr;
                                mem.data  <= {2'b00, adc_ch1, 2'b00, adc_ch0};
                                wr_ptr    <= wr_ptr + 1'b1;
                                cap_count <= cap_count + 1'b1;
                                if (wr_ptr == last_ptr) begin
                                    state    <= DONE;
                                    cap_busy <= 1'b0;
                                    cap_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_mem_capture.sv
// Scoreboard bench for adc_mem_capture: expected writes are queued as samples are driven
// and popped by a monitor whenever the BRAM write strobe is seen.
module tb_adc_mem_capture;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cap_start = 1'b0;
    logic          cap_abort = 1'b0;
    logic [AW-1:0] cap_len = '0;
    logic [7:0]    cap_decim = '0;
    logic          trig_mode = 1'b0;
    logic          trig = 1'b0;
    logic          adc_valid = 1'b0;
    logic [13:0]   adc_ch0 = '0;
    logic [13:0]   adc_ch1 = '0;
    logic          cap_busy;
    logic          cap_done;
    logic [AW:0]   cap_count;

    adc_mem_capture_if #(.ADDR_WIDTH(AW)) mif ();

    adc_mem_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_start (cap_start),
        .cap_abort (cap_abort),
        .cap_len   (cap_len),
        .cap_decim (cap_decim),
        .trig_mode (trig_mode),
        .trig      (trig),
        .adc_valid (adc_valid),
        .adc_ch0   (adc_ch0),
        .adc_ch1   (adc_ch1),
        .mem       (mif),
        .cap_busy  (cap_busy),
        .cap_done  (cap_done),
        .cap_count (cap_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic [AW+31:0] exp_q[$];
    int unsigned    wr_cyc[$];

    bit            m_active = 1'b0;
    int            m_cnt, m_decim, m_left;
    logic [AW-1:0] m_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (mif.wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            check_val("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check_val("wr_addr", 64'(mif.addr), 64'(e[AW+31:32]));
                check_val("wr_data", 64'(mif.data), 64'(e[31:0]));
            end
        end
    end

    task automatic model_start(input int len, input int decim);
        m_active = 1'b1;
        m_cnt    = 0;
        m_decim  = decim;
        m_left   = (len == 0) ? (1 << AW) : len;
        m_addr   = '0;
    endtask

    // Drives one cycle of ADC input, predicting the write it should cause.
    task automatic drive(input logic v, input logic [13:0] c0, input logic [13:0] c1);
        adc_valid = v;
        adc_ch0   = c0;
        adc_ch1   = c1;
        if (v && m_active) begin
            if (m_cnt == 0) begin
                exp_q.push_back({m_addr, 2'b00, c1, 2'b00, c0});
                m_addr = m_addr + 1'b1;
                m_left--;
                if (m_left == 0) m_active = 1'b0;
            end
            m_cnt = (m_cnt == m_decim) ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input int len, input int decim, input logic mode);
        cap_len   = AW'(len);
        cap_decim = 8'(decim);
        trig_mode = mode;
        cap_start = 1'b1;
        drive(1'b0, '0, '0);
        cap_start = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_val("rst_busy", 64'(cap_busy), 64'd0);
        check_val("rst_done", 64'(cap_done), 64'd0);
        check_val("rst_count", 64'(cap_count), 64'd0);
        check_val("rst_wr_en", 64'(mif.wr_en), 64'd0);
        check_val("rst_addr", 64'(mif.addr), 64'd0);
        check_val("rst_data", 64'(mif.data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, '0, '0);

        // T1: immediate capture of four samples
        start_cap(4, 0, 1'b0);
        check_val("t1_busy_start", 64'(cap_busy), 64'd1);
        check_val("t1_done_start", 64'(cap_done), 64'd0);
        model_start(4, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 14'(50 + 100 * i), 14'(100 + 100 * i));
        check_val("t1_done", 64'(cap_done), 64'd1);
        check_val("t1_busy", 64'(cap_busy), 64'd0);
        check_val("t1_last_wr", 64'(mif.wr_en), 64'd1);
        check_val("t1_count", 64'(cap_count), 64'd4);
        for (int i = 0; i < 3; i++) drive(1'b1, 14'(i), 14'(i));
        check_val("t1_done_hold", 64'(cap_done), 64'd1);
        check_val("t1_count_hold", 64'(cap_count), 64'd4);

        // T2: keep one in three, ch0 carries a cycle stamp
        start_cap(3, 2, 1'b0);
        model_start(3, 2);
        for (int i = 0; i < 10; i++) drive(1'b1, 14'(cyc), 14'(i));
        check_val("t2_count", 64'(cap_count), 64'd3);
        check_val("t2_done", 64'(cap_done), 64'd1);

        // T3: trigger already high at start must not count as an edge
        trig = 1'b1;
        start_cap(2, 0, 1'b1);
        check_val("t3_done_clr", 64'(cap_done), 64'd0);
        trig = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 14'(i), 14'(i));
        check_val("t3_busy_arm", 64'(cap_busy), 64'd1);
        check_val("t3_count_arm", 64'(cap_count), 64'd0);
        trig = 1'b1;
        drive(1'b1, 14'd999, 14'd999);
        model_start(2, 0);
        drive(1'b1, 14'd11, 14'd22);
        drive(1'b1, 14'd33, 14'd44);
        check_val("t3_done", 64'(cap_done), 64'd1);
        trig = 1'b0;

        // T4: abort coinciding with what would be the fourth accept
        start_cap(8, 0, 1'b0);
        model_start(8, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 14'(7 * i), 14'(3 * i));
        m_active  = 1'b0;
        cap_abort = 1'b1;
        drive(1'b1, 14'd500, 14'd600);
        cap_abort = 1'b0;
        check_val("t4_busy", 64'(cap_busy), 64'd0);
        check_val("t4_done", 64'(cap_done), 64'd0);
        check_val("t4_count", 64'(cap_count), 64'd3);
        check_val("t4_wr_en", 64'(mif.wr_en), 64'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, 14'(i), 14'(i));
        check_val("t4_count_hold", 64'(cap_count), 64'd3);

        // T5: len=0 fills the whole buffer, then a short restart
        start_cap(0, 0, 1'b0);
        model_start(0, 0);
        for (int i = 0; i < 16; i++) drive(1'b1, 14'(1000 + i), 14'(2000 + i));
        check_val("t5_count", 64'(cap_count), 64'd16);
        check_val("t5_done", 64'(cap_done), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 14'(i), 14'(i));
        start_cap(2, 0, 1'b0);
        check_val("t5_done_clr", 64'(cap_done), 64'd0);
        check_val("t5_count_clr", 64'(cap_count), 64'd0);
        model_start(2, 0);
        drive(1'b1, 14'd77, 14'd88);
        drive(1'b1, 14'd99, 14'd111);
        check_val("t5_re_count", 64'(cap_count), 64'd2);

        // T6: alternating valid with an ignored start, then abort-in-DONE and reset mid-capture
        drive(1'b0, '0, '0);
        wr_cyc.delete();
        start_cap(4, 0, 1'b0);
        model_start(4, 0);
        for (int i = 0; i < 8; i++) begin
            cap_start = (i == 3);
            cap_len   = (i == 3) ? AW'(1) : cap_len;
            drive((i % 2) == 0, 14'(300 + i), 14'(400 + i));
        end
        cap_start = 1'b0;
        check_val("t6_count", 64'(cap_count), 64'd4);
        check_val("t6_done", 64'(cap_done), 64'd1);
        check_val("t6_nwr", 64'(wr_cyc.size()), 64'd4);
        for (int i = 1; i < wr_cyc.size(); i++)
            check_val("t6_gap", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd2);
        cap_abort = 1'b1;
        drive(1'b0, '0, '0);
        cap_abort = 1'b0;
        check_val("t6_abort_done", 64'(cap_done), 64'd0);

        start_cap(8, 0, 1'b0);
        model_start(8, 0);
        drive(1'b1, 14'd5, 14'd6);
        drive(1'b1, 14'd7, 14'd8);
        m_active = 1'b0;
        rst = 1'b1;
        drive(1'b1, 14'd9, 14'd10);
        check_val("t6_rst_wr_en", 64'(mif.wr_en), 64'd0);
        check_val("t6_rst_addr", 64'(mif.addr), 64'd0);
        check_val("t6_rst_data", 64'(mif.data), 64'd0);
        check_val("t6_rst_busy", 64'(cap_busy), 64'd0);
        check_val("t6_rst_count", 64'(cap_count), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 14'(i), 14'(i));

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
